// File: rtl/timer_pkg.sv
// Shared definitions for the interval-timer controller: state encodings and
// the counter datapath width.
package timer_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/count8a.sv
// 8-bit loadable up-counter driven by timer_ctrl8; load takes priority over enable.
module count8a
    import timer_pkg::*;
(
    input  logic             Clk,
    input  logic             Res,
    input  logic             En,
    input  logic             Load,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge Clk or negedge Res) begin
        if (!Res) begin
            cnt <= '0;
        end else if (Load) begin
            cnt <= cnt_in;
        end else if (En) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/eq_cmp8.sv
// 8-bit equality comparator: per-bit xnor reduced by an and-tree.
module eq_cmp8
    import timer_pkg::*;
(
    input  logic [CNT_W-1:0] a,
    input  logic [CNT_W-1:0] b,
    output logic             eq
);

    logic [CNT_W-1:0] bit_eq;

    assign bit_eq = a ~^ b;
    assign eq     = &bit_eq;

endmodule

// File: rtl/timer_ctrl8.sv
// Interval-timer controller: loads a preset into count8a, enables counting up
// to a captured period, and emits a one-cycle tick at each terminal count.
module timer_ctrl8
    import timer_pkg::*;
#(
    parameter logic AUTO_RELOAD = 1'b1
) (
    input  logic             Clk,
    input  logic             Res,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] preset_in,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] cnt,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_din,
    output logic             busy,
    output logic             done,
    output logic             tick,
    output state_e           state_dbg
);

    // start/stop are level requests sampled on every rising edge; there is no
    // ready back-pressure. start counts only in IDLE/DONE, stop always wins.

    state_e           state;
    state_e           state_nx;
    logic             capture;
    logic             tick_nx;
    logic             at_period;
    logic [CNT_W-1:0] preset_q;
    logic [CNT_W-1:0] period_q;

    eq_cmp8 u_eq (
        .a  (cnt),
        .b  (period_q),
        .eq (at_period)
    );

    always_ff @(posedge Clk or negedge Res) begin
        if (!Res) begin
            state    <= ST_IDLE;
            tick     <= 1'b0;
            preset_q <= '0;
            period_q <= '0;
        end else begin
            state <= state_nx;
            tick  <= tick_nx;
            if (capture) begin
                preset_q <= preset_in;
                period_q <= period_in;
            end
        end
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        tick_nx  = 1'b0;
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    capture  = 1'b1;
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_load = 1'b1;
                state_nx = stop ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                // Holding cnt_en low at the terminal value parks the counter on period_q.
                cnt_en = !at_period && !stop;
                if (stop) begin
                    state_nx = ST_IDLE;
                end else if (at_period) begin
                    tick_nx  = 1'b1;
                    state_nx = AUTO_RELOAD ? ST_LOAD : ST_DONE;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_nx = ST_IDLE;
                end else if (start) begin
                    capture  = 1'b1;
                    state_nx = ST_LOAD;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign cnt_din   = preset_q;
    assign busy      = (state == ST_LOAD) || (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_timer_ctrl8.sv
// Bench for timer_ctrl8: one-shot and auto-reload controllers, each wired to a
// count8a, driven by shared stimulus and checked every cycle against a model.
module tb_timer_ctrl8;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start     = 1'b0;
    logic       stop      = 1'b0;
    logic [7:0] preset_in = 8'h00;
    logic [7:0] period_in = 8'h00;

    // index 0: one-shot, index 1: auto-reload
    logic [7:0] cnt_w      [2];
    logic       cnt_en_w   [2];
    logic       cnt_load_w [2];
    logic [7:0] cnt_din_w  [2];
    logic       busy_w     [2];
    logic       done_w     [2];
    logic       tick_w     [2];
    logic [1:0] state_w    [2];

    timer_ctrl8 #(.AUTO_RELOAD(1'b0)) u_dut0 (
        .Clk(clk), .Res(rst_n), .start(start), .stop(stop),
        .preset_in(preset_in), .period_in(period_in), .cnt(cnt_w[0]),
        .cnt_en(cnt_en_w[0]), .cnt_load(cnt_load_w[0]), .cnt_din(cnt_din_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .tick(tick_w[0]), .state_dbg(state_w[0])
    );
    count8a u_cnt0 (
        .Clk(clk), .Res(rst_n), .En(cnt_en_w[0]), .Load(cnt_load_w[0]),
        .cnt_in(cnt_din_w[0]), .cnt(cnt_w[0])
    );

    timer_ctrl8 #(.AUTO_RELOAD(1'b1)) u_dut1 (
        .Clk(clk), .Res(rst_n), .start(start), .stop(stop),
        .preset_in(preset_in), .period_in(period_in), .cnt(cnt_w[1]),
        .cnt_en(cnt_en_w[1]), .cnt_load(cnt_load_w[1]), .cnt_din(cnt_din_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .tick(tick_w[1]), .state_dbg(state_w[1])
    );
    count8a u_cnt1 (
        .Clk(clk), .Res(rst_n), .En(cnt_en_w[1]), .Load(cnt_load_w[1]),
        .cnt_in(cnt_din_w[1]), .cnt(cnt_w[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q [$];

    task automatic chk1(input string name, input logic act, input logic exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, want %b", name, $time, act, exp_v);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%02h, want 0x%02h", name, $time, act, exp_v);
        end
    endtask

    // behavioural model: phase, remaining RUN cycles, counter value
    int         m_phase  [2] = '{P_IDLE, P_IDLE};
    int         m_left   [2] = '{0, 0};
    logic [7:0] m_preset [2] = '{8'h00, 8'h00};
    logic [7:0] m_period [2] = '{8'h00, 8'h00};
    logic [7:0] m_cnt    [2] = '{8'h00, 8'h00};
    logic       m_tick   [2] = '{1'b0, 1'b0};
    logic [7:0] m_diff;

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_phase[k]  = P_IDLE;
                m_left[k]   = 0;
                m_preset[k] = 8'h00;
                m_period[k] = 8'h00;
                m_cnt[k]    = 8'h00;
                m_tick[k]   = 1'b0;
            end else begin
                m_tick[k] = 1'b0;
                case (m_phase[k])
                    P_IDLE, P_DONE: begin
                        if (stop) begin
                            m_phase[k] = P_IDLE;
                        end else if (start) begin
                            m_preset[k] = preset_in;
                            m_period[k] = period_in;
                            m_phase[k]  = P_LOAD;
                        end
                    end
                    P_LOAD: begin
                        m_cnt[k]   = m_preset[k];
                        m_diff     = m_period[k] - m_preset[k];
                        m_left[k]  = int'(m_diff) + 1;
                        m_phase[k] = stop ? P_IDLE : P_RUN;
                    end
                    default: begin
                        if (stop) begin
                            m_phase[k] = P_IDLE;
                        end else if (m_left[k] == 1) begin
                            m_tick[k]  = 1'b1;
                            m_phase[k] = (k == 1) ? P_LOAD : P_DONE;
                        end else begin
                            m_cnt[k]  = m_cnt[k] + 8'd1;
                            m_left[k] = m_left[k] - 1;
                        end
                    end
                endcase
            end
        end
    end

    // compare process: every falling edge, both instances
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk8($sformatf("cnt[%0d]", k), cnt_w[k], m_cnt[k]);
            chk8($sformatf("cnt_din[%0d]", k), cnt_din_w[k], m_preset[k]);
            chk8($sformatf("state[%0d]", k), {6'd0, state_w[k]}, 8'(m_phase[k]));
            chk1($sformatf("cnt_en[%0d]", k), cnt_en_w[k],
                 (m_phase[k] == P_RUN) && (m_left[k] != 1) && !stop);
            chk1($sformatf("cnt_load[%0d]", k), cnt_load_w[k], m_phase[k] == P_LOAD);
            chk1($sformatf("busy[%0d]", k), busy_w[k],
                 (m_phase[k] == P_LOAD) || (m_phase[k] == P_RUN));
            chk1($sformatf("done[%0d]", k), done_w[k], m_phase[k] == P_DONE);
            chk1($sformatf("tick[%0d]", k), tick_w[k], m_tick[k]);
        end
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] p, input logic [7:0] q);
        start     = 1'b1;
        preset_in = p;
        period_in = q;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic wait_cnt(input int k, input logic [7:0] val, input int budget);
        int c;
        c = 0;
        while (cnt_w[k] !== val && c < budget) begin
            step(1);
            c++;
        end
        chk1($sformatf("wait_cnt_%02h", val), cnt_w[k] === val, 1'b1);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done_w[0] !== 1'b1 && cycles < budget) begin
            step(1);
            cycles++;
        end
    endtask

    task automatic measure_ticks(input int k, input int n_ticks, input int budget,
                                 output logic all_busy);
        int last;
        int seen;
        logic [7:0] ival;
        last = -1;
        seen = 0;
        all_busy = 1'b1;
        for (int c = 0; c < budget && seen < n_ticks; c++) begin
            step(1);
            all_busy = all_busy & busy_w[k];
            if (tick_w[k]) begin
                if (last >= 0 && exp_q.size() > 0) begin
                    ival = exp_q.pop_front();
                    chk8("tick_interval", 8'(c - last), ival);
                end
                last = c;
                seen++;
            end
        end
        if (seen < n_ticks) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: got %0d ticks, want %0d", seen, n_ticks);
        end
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic all_busy;

        // reset release and reset state
        step(2);
        rst_n = 1'b1;
        step(2);
        chk1("reset_busy", busy_w[1], 1'b0);
        chk8("reset_cnt_din", cnt_din_w[1], 8'h00);

        // asynchronous reset mid-RUN at cnt=0x04
        pulse_start(8'h02, 8'h20);
        step(1);
        wait_cnt(1, 8'h04, 20);
        chk8("pre_reset_cnt_din", cnt_din_w[1], 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk1("async_busy", busy_w[k], 1'b0);
            chk1("async_done", done_w[k], 1'b0);
            chk1("async_tick", tick_w[k], 1'b0);
            chk1("async_cnt_en", cnt_en_w[k], 1'b0);
            chk1("async_cnt_load", cnt_load_w[k], 1'b0);
            chk8("async_cnt_din", cnt_din_w[k], 8'h00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        preset_in = 8'h33;
        period_in = 8'h55;
        step(4);
        chk1("stale_busy", busy_w[1], 1'b0);
        chk8("stale_cnt_din", cnt_din_w[1], 8'h00);

        // auto-reload preset 0x00 period 0x09: tick every 11 cycles
        pulse_start(8'h00, 8'h09);
        chk1("ar_load", cnt_load_w[1], 1'b1);
        step(1);
        chk1("ar_load_1cyc", cnt_load_w[1], 1'b0);
        chk8("ar_cnt_preset", cnt_w[1], 8'h00);
        repeat (3) exp_q.push_back(8'd11);
        measure_ticks(1, 4, 80, all_busy);
        chk1("ar_busy_held", all_busy, 1'b1);
        pulse_stop();

        // one-shot FA..03 wrap: LOAD + 10 RUN cycles, then DONE with a tick
        for (int rep = 0; rep < 2; rep++) begin
            pulse_start(8'hFA, 8'h03);
            wait_done(40, cyc);
            chk8("os_cycles_to_done", 8'(cyc), 8'd11);
            chk1("os_tick", tick_w[0], 1'b1);
            step(3);
            chk1("os_done_held", done_w[0], 1'b1);
            chk8("os_cnt_held", cnt_w[0], 8'h03);
        end

        // stop at cnt=0x05 in RUN
        pulse_stop();
        pulse_start(8'h00, 8'h20);
        step(1);
        wait_cnt(0, 8'h05, 20);
        stop = 1'b1;
        #1;
        chk1("stop_cnt_en", cnt_en_w[0], 1'b0);
        step(1);
        stop = 1'b0;
        chk1("stop_idle", busy_w[0], 1'b0);
        step(3);
        chk8("stop_cnt_frozen", cnt_w[0], 8'h05);
        chk1("stop_no_tick", tick_w[0], 1'b0);

        // start+stop in IDLE stays idle; start during RUN is ignored
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        chk1("startstop_idle", busy_w[0], 1'b0);
        pulse_start(8'h00, 8'h10);
        step(3);
        pulse_start(8'h00, 8'h40);
        wait_done(40, cyc);
        chk8("ignored_start_cnt", cnt_w[0], 8'h10);
        chk8("ignored_start_din", cnt_din_w[0], 8'h00);

        // preset == period: 1-cycle RUN, tick every 2 cycles
        pulse_stop();
        pulse_start(8'h7F, 8'h7F);
        repeat (3) exp_q.push_back(8'd2);
        measure_ticks(1, 4, 20, all_busy);
        pulse_stop();

        // randomized traffic checked by the model
        for (int i = 0; i < 1500; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 29) == 0);
            preset_in = 8'($urandom);
            period_in = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                     : preset_in + 8'($urandom_range(0, 12));
            step(1);
        end
        start = 1'b0;
        stop  = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
